// File: rtl/operand_fetch_fwd.sv
// SPU 128 x 128-bit register file with dual-pipe writeback and one-cycle registered operand fetch.
// Define OPERAND_FWD_TAPS_EN to let the in-flight result taps override write-through and array data.
module operand_fetch_fwd #(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned FWD_STAGES = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                rd_valid,
    input  logic [ADDR_W-1:0]                   ra_addr,
    input  logic [ADDR_W-1:0]                   rb_addr,
    input  logic [ADDR_W-1:0]                   rc_addr,
    input  logic [DATA_W-1:0]                   rt_wb_e,
    input  logic [DATA_W-1:0]                   rt_wb_o,
    input  logic [ADDR_W-1:0]                   rt_addr_wb_e,
    input  logic [ADDR_W-1:0]                   rt_addr_wb_o,
    input  logic                                reg_write_wb_e,
    input  logic                                reg_write_wb_o,
    input  logic [FWD_STAGES-1:0][DATA_W-1:0]   fwd_data_e,
    input  logic [FWD_STAGES-1:0][DATA_W-1:0]   fwd_data_o,
    input  logic [FWD_STAGES-1:0][ADDR_W-1:0]   fwd_addr_e,
    input  logic [FWD_STAGES-1:0][ADDR_W-1:0]   fwd_addr_o,
    input  logic [FWD_STAGES-1:0]               fwd_we_e,
    input  logic [FWD_STAGES-1:0]               fwd_we_o,
    output logic [DATA_W-1:0]                   ra,
    output logic [DATA_W-1:0]                   rb,
    output logic [DATA_W-1:0]                   rc,
    output logic                                operands_valid,
    output logic                                wb_collision
);

    localparam int unsigned NumRegs = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NumRegs];
    logic [ADDR_W-1:0] src_addr [3];
    logic [DATA_W-1:0] src_val [3];

    // Odd write is issued second so it wins on an address clash.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NumRegs); i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (reg_write_wb_e) regs[rt_addr_wb_e] <= rt_wb_e;
            if (reg_write_wb_o) regs[rt_addr_wb_o] <= rt_wb_o;
        end
    end

    assign src_addr[0] = ra_addr;
    assign src_addr[1] = rb_addr;
    assign src_addr[2] = rc_addr;

    // Sources are applied lowest priority first; the last match assigned wins.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            src_val[k] = regs[src_addr[k]];
            if (reg_write_wb_e && rt_addr_wb_e == src_addr[k]) src_val[k] = rt_wb_e;
            if (reg_write_wb_o && rt_addr_wb_o == src_addr[k]) src_val[k] = rt_wb_o;
`ifdef OPERAND_FWD_TAPS_EN
            for (int s = int'(FWD_STAGES) - 1; s >= 0; s--) begin
                if (fwd_we_e[s] && fwd_addr_e[s] == src_addr[k]) src_val[k] = fwd_data_e[s];
                if (fwd_we_o[s] && fwd_addr_o[s] == src_addr[k]) src_val[k] = fwd_data_o[s];
            end
`endif
        end
    end

`ifndef OPERAND_FWD_TAPS_EN
    logic unused_taps;
    assign unused_taps = ^{fwd_data_e, fwd_data_o, fwd_addr_e, fwd_addr_o, fwd_we_e, fwd_we_o};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ra             <= '0;
            rb             <= '0;
            rc             <= '0;
            operands_valid <= 1'b0;
            wb_collision   <= 1'b0;
        end else begin
            operands_valid <= rd_valid;
            wb_collision   <= reg_write_wb_e && reg_write_wb_o && (rt_addr_wb_e == rt_addr_wb_o);
            if (rd_valid) begin
                ra <= src_val[0];
                rb <= src_val[1];
                rc <= src_val[2];
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch_fwd.sv
// Randomized and directed bench for operand_fetch_fwd against a priority-list reference model.
module tb_operand_fetch_fwd;

    localparam int DW = 128;
    localparam int AW = 7;
    localparam int FS = 4;
`ifdef OPERAND_FWD_TAPS_EN
    localparam bit TapsEn = 1'b1;
`else
    localparam bit TapsEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic rd_valid;
    logic [AW-1:0] ra_addr, rb_addr, rc_addr;
    logic [DW-1:0] rt_wb_e, rt_wb_o;
    logic [AW-1:0] rt_addr_wb_e, rt_addr_wb_o;
    logic reg_write_wb_e, reg_write_wb_o;
    logic [FS-1:0][DW-1:0] fwd_data_e, fwd_data_o;
    logic [FS-1:0][AW-1:0] fwd_addr_e, fwd_addr_o;
    logic [FS-1:0] fwd_we_e, fwd_we_o;
    logic [DW-1:0] ra, rb, rc;
    logic operands_valid, wb_collision;

    operand_fetch_fwd dut (
        .clk(clk), .reset(reset), .rd_valid(rd_valid),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .rc_addr(rc_addr),
        .rt_wb_e(rt_wb_e), .rt_wb_o(rt_wb_o),
        .rt_addr_wb_e(rt_addr_wb_e), .rt_addr_wb_o(rt_addr_wb_o),
        .reg_write_wb_e(reg_write_wb_e), .reg_write_wb_o(reg_write_wb_o),
        .fwd_data_e(fwd_data_e), .fwd_data_o(fwd_data_o),
        .fwd_addr_e(fwd_addr_e), .fwd_addr_o(fwd_addr_o),
        .fwd_we_e(fwd_we_e), .fwd_we_o(fwd_we_o),
        .ra(ra), .rb(rb), .rc(rc),
        .operands_valid(operands_valid), .wb_collision(wb_collision)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [128];
    logic [DW-1:0] exp_ra, exp_rb, exp_rc;
    logic exp_valid, exp_coll;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Walk the sources youngest/highest priority first and return the first hit.
    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        if (TapsEn) begin
            for (int s = 0; s < FS; s++) begin
                if (fwd_we_o[s] && fwd_addr_o[s] == a) return fwd_data_o[s];
                if (fwd_we_e[s] && fwd_addr_e[s] == a) return fwd_data_e[s];
            end
        end
        if (reg_write_wb_o && rt_addr_wb_o == a) return rt_wb_o;
        if (reg_write_wb_e && rt_addr_wb_e == a) return rt_wb_e;
        return mem[a];
    endfunction

    task automatic clear_inputs();
        rd_valid = 0; ra_addr = 0; rb_addr = 0; rc_addr = 0;
        rt_wb_e = 0; rt_wb_o = 0; rt_addr_wb_e = 0; rt_addr_wb_o = 0;
        reg_write_wb_e = 0; reg_write_wb_o = 0;
        fwd_data_e = '0; fwd_data_o = '0; fwd_addr_e = '0; fwd_addr_o = '0;
        fwd_we_e = '0; fwd_we_o = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 128; i++) mem[i] = '0;
        exp_ra = '0; exp_rb = '0; exp_rc = '0; exp_valid = 0; exp_coll = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".ra"}, ra, exp_ra);
        check({tag, ".rb"}, rb, exp_rb);
        check({tag, ".rc"}, rc, exp_rc);
        check({tag, ".valid"}, DW'(operands_valid), DW'(exp_valid));
        check({tag, ".coll"}, DW'(wb_collision), DW'(exp_coll));
    endtask

    task automatic step(input string tag);
        if (rd_valid) begin
            exp_ra = ref_read(ra_addr);
            exp_rb = ref_read(rb_addr);
            exp_rc = ref_read(rc_addr);
        end
        exp_valid = rd_valid;
        exp_coll  = reg_write_wb_e && reg_write_wb_o && (rt_addr_wb_e == rt_addr_wb_o);
        @(posedge clk);
        if (reg_write_wb_e) mem[rt_addr_wb_e] = rt_wb_e;
        if (reg_write_wb_o) mem[rt_addr_wb_o] = rt_wb_o;
        #1;
        check_outputs(tag);
    endtask

    task automatic read3(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c);
        rd_valid = 1; ra_addr = a; rb_addr = b; rc_addr = c;
    endtask

    initial begin
        reset = 0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        reset = 1;

        read3(5, 6, 7);
        step("rd_after_reset");
        clear_inputs();

        // Write r10 and read it in the same cycle, then again a cycle later.
        reg_write_wb_e = 1; rt_addr_wb_e = 10; rt_wb_e = {DW/4{4'hA}};
        read3(10, 10, 10);
        step("wr_through");
        clear_inputs();
        read3(10, 0, 10);
        step("rd_r10");
        clear_inputs();

        reg_write_wb_e = 1; rt_addr_wb_e = 3; rt_wb_e = {DW/4{4'h1}};
        reg_write_wb_o = 1; rt_addr_wb_o = 3; rt_wb_o = {DW/4{4'h2}};
        step("collide");
        clear_inputs();
        read3(3, 3, 3);
        step("rd_r3");
        clear_inputs();

        reg_write_wb_e = 1; rt_addr_wb_e = 20; rt_wb_e = 'h5;
        step("wr_r20");
        clear_inputs();
        fwd_we_e[3] = 1; fwd_addr_e[3] = 20; fwd_data_e[3] = 'h7;
        fwd_we_o[1] = 1; fwd_addr_o[1] = 20; fwd_data_o[1] = 'h9;
        read3(20, 20, 3);
        step("tap_r20");
        check("tap_r20.direct", ra, TapsEn ? DW'('h9) : DW'('h5));
        clear_inputs();

        reg_write_wb_o = 1; rt_addr_wb_o = 8; rt_wb_o = 'h1;
        step("wr_r8");
        clear_inputs();
        fwd_we_e[0] = 0; fwd_addr_e[0] = 8; fwd_data_e[0] = 'hDEAD;
        fwd_we_o[0] = 0; fwd_addr_o[0] = 8; fwd_data_o[0] = 'hBEEF;
        read3(8, 8, 8);
        step("tap_disabled");
        clear_inputs();

        read3(3, 10, 20);
        step("b2b0");
        read3(10, 8, 3);
        step("b2b1");
        read3(20, 3, 8);
        step("b2b2");
        clear_inputs();
        step("b2b_idle");

        read3(10, 10, 10);
        step("pre_reset");
        // Asynchronous reset mid-cycle with a read pending.
        read3(3, 3, 3);
        #2;
        reset = 0;
        #1;
        model_reset();
        check_outputs("async_reset");
        @(negedge clk);
        reset = 1;
        clear_inputs();

        for (int n = 0; n < 400; n++) begin
            rd_valid = ($urandom_range(0, 3) != 0);
            ra_addr = AW'($urandom_range(0, 15));
            rb_addr = AW'($urandom_range(0, 15));
            rc_addr = AW'($urandom_range(0, 15));
            reg_write_wb_e = $urandom_range(0, 1) == 1;
            reg_write_wb_o = $urandom_range(0, 1) == 1;
            rt_addr_wb_e = AW'($urandom_range(0, 15));
            rt_addr_wb_o = AW'($urandom_range(0, 15));
            rt_wb_e = {$urandom(), $urandom(), $urandom(), $urandom()};
            rt_wb_o = {$urandom(), $urandom(), $urandom(), $urandom()};
            for (int s = 0; s < FS; s++) begin
                fwd_we_e[s] = $urandom_range(0, 2) == 0;
                fwd_we_o[s] = $urandom_range(0, 2) == 0;
                fwd_addr_e[s] = AW'($urandom_range(0, 15));
                fwd_addr_o[s] = AW'($urandom_range(0, 15));
                fwd_data_e[s] = {$urandom(), $urandom(), $urandom(), $urandom()};
                fwd_data_o[s] = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/operand_fetch_fwd.md
Name: operand_fetch_fwd

Overview:
- SPU register file (128 x 128-bit) and operand fetch stage. It is the consumer side of the execution-pipe writeback interface.
- It accepts writebacks from the even and odd pipes. It returns ra/rb/rc operands for the next issued instruction.
- Operands are forwarded from in-flight result stages, so dependent instructions see the newest value.
- Sits between the decode/issue logic and the execution units.

Parameters:
- DATA_W, 128, register/operand width in bits
- ADDR_W, 7, register address width (128 registers)
- FWD_STAGES, 4, number of forwarding taps per pipe (index 0 youngest, FWD_STAGES-1 oldest)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- rd_valid  in  1  operand read request this cycle
- ra_addr, rb_addr, rc_addr  in  ADDR_W each  source register addresses
- rt_wb_e, rt_wb_o  in  DATA_W each  even/odd pipe writeback data
- rt_addr_wb_e, rt_addr_wb_o  in  ADDR_W each  writeback destination addresses
- reg_write_wb_e, reg_write_wb_o  in  1 each  writeback enables
- fwd_data_e, fwd_data_o  in  FWD_STAGES x DATA_W  in-flight result taps
- fwd_addr_e, fwd_addr_o  in  FWD_STAGES x ADDR_W  tap destination addresses
- fwd_we_e, fwd_we_o  in  FWD_STAGES  tap write-valid bits
- ra, rb, rc  out  DATA_W each  fetched operands (registered)
- operands_valid  out  1  ra/rb/rc valid this cycle
- wb_collision  out  1  both pipes wrote the same address last cycle (registered)

Behaviour:
- Reset (reset=0, asynchronous):
  - all 128 registers cleared to 0
  - ra=rb=rc=0, operands_valid=0, wb_collision=0
  - any in-progress read or write is discarded
- Write:
  - On each rising edge, reg_write_wb_e=1 writes rt_wb_e to rt_addr_wb_e. Same for the odd pipe.
  - All 128 addresses are writable; there is no hard-wired zero register.
  - Both enables set with equal addresses: the odd pipe wins, and wb_collision=1 on the next cycle.
  - wb_collision otherwise drops to 0 on the next edge.
- Read latency: 1 cycle.
  - rd_valid=1 in cycle N gives ra/rb/rc and operands_valid=1 in cycle N+1.
  - rd_valid=0 gives operands_valid=0 in N+1; ra/rb/rc hold their previous values.
- Per-operand source selection in cycle N, highest priority first:
  1. Forwarding taps with fwd_we=1 and a matching address, stage 0 first, then stage 1, and so on. At equal stage, odd beats even.
  2. Same-cycle writeback with a matching address (write-through). Odd beats even.
  3. Register array contents.
- Taps with fwd_we=0 never match, whatever their address.
- Each operand selects independently. Identical addresses on ra/rb/rc all return the same value.
- The write and read of the same edge are consistent: a read in N+1 of an address written at the end of N returns the new value with no forwarding needed.
- No stalls and no backpressure. The block accepts a read every cycle.

Optional Feature:
- Macro: OPERAND_FWD_TAPS_EN
- Defined: the taps fwd_data/fwd_addr/fwd_we take part in priority levels 1–3 as above.
- Undefined:
  - tap ports stay present but are ignored
  - selection uses only write-through (level 2) then the array (level 3)
  - issue logic must then stall dependent instructions until writeback

Test Plan:
- Reset then read r5, r6, r7 → next cycle ra=rb=rc=0, operands_valid=1. Assert reset mid-read → outputs 0 immediately (asynchronous).
- Even pipe writes r10=0xAAAA…AAAA, then read r10 one cycle later → ra=0xAAAA…AAAA. Read r10 in the same cycle as the write → also 0xAAAA…AAAA (write-through).
- Even and odd pipes both write r3, even=0x1111…, odd=0x2222… → wb_collision=1 next cycle; subsequent read of r3 returns 0x2222….
- r20=0x5 in the array; fwd_data_e[3]=0x7 and fwd_data_o[1]=0x9 both target r20 with we=1; read r20 → 0x9 (youngest tap wins). Same stimulus with OPERAND_FWD_TAPS_EN undefined → 0x5.
- Tap stage 0 addr r8 with fwd_we=0 and data 0xDEAD, array r8=0x1 → ra=0x1 (disabled tap ignored).
- Back-to-back rd_valid for 3 cycles, then rd_valid=0 → operands_valid goes 1,1,1,0 and ra holds the last value during the 0 cycle.
